// File: rtl/conv_sequencer_layer6.sv
// Address/control sequencer for VGG16 conv3_2 (3x3, stride 1, pad 1): one MAC issue per
// cycle over oc/row/col/ic/tap, with a read-latency delay line driving the accumulator strobes.
module conv_sequencer_layer6 #(
    parameter int IN_CH   = 256,
    parameter int OUT_CH  = 256,
    parameter int FMAP_H  = 56,
    parameter int FMAP_W  = 56,
    parameter int MEM_LAT = 2,
    parameter int FA_W    = 20,
    parameter int WA_W    = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic [FA_W-1:0]           feat_addr,
    output logic                      feat_pad,
    output logic [WA_W-1:0]           wgt_addr,
    output logic [$clog2(OUT_CH)-1:0] bias_addr,
    output logic                      mac_en,
    output logic                      mac_clr,
    output logic                      valid_in_bias,
    output logic [$clog2(FMAP_H)-1:0] out_row,
    output logic [$clog2(FMAP_W)-1:0] out_col
);
    localparam int OCW = $clog2(OUT_CH);
    localparam int RW  = $clog2(FMAP_H);
    localparam int CW  = $clog2(FMAP_W);
    localparam int ICW = $clog2(IN_CH);
    localparam int DL  = MEM_LAT + 1;
    localparam int FW  = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    typedef struct packed {
        logic           issue;
        logic           first;
        logic           last;
        logic [OCW-1:0] oc;
        logic [RW-1:0]  row;
        logic [CW-1:0]  col;
    } dl_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [OCW-1:0]  oc_q, oc_d, n_oc, a_oc;
    logic [RW-1:0]   row_q, row_d, n_row, a_row, r;
    logic [CW-1:0]   col_q, col_d, n_col, a_col, c;
    logic [ICW-1:0]  ic_q, ic_d, n_ic, a_ic;
    logic [1:0]      ky_q, ky_d, n_ky, a_ky;
    logic [1:0]      kx_q, kx_d, n_kx, a_kx;
    logic [3:0]      tap;
    logic            tap_last, ic_last, col_last, row_last, oc_last;
    logic            pix_last, layer_last, first, issue, load_addr, pad;
    logic [FA_W-1:0] feat_addr_q, feat_addr_d;
    logic            feat_pad_q, feat_pad_d;
    logic [WA_W-1:0] wgt_addr_q, wgt_addr_d;
    dl_t [DL:1]      dl_q, dl_d;
    dl_t             head;
    logic            unused_first;

    // Wrap detection and next counter values for the tap currently on the address bus.
    always_comb begin
        tap_last   = (ky_q == 2'd2) && (kx_q == 2'd2);
        ic_last    = ic_q  == ICW'(IN_CH - 1);
        col_last   = col_q == CW'(FMAP_W - 1);
        row_last   = row_q == RW'(FMAP_H - 1);
        oc_last    = oc_q  == OCW'(OUT_CH - 1);
        pix_last   = tap_last && ic_last;
        layer_last = pix_last && col_last && row_last && oc_last;
        first      = (ic_q == '0) && (ky_q == 2'd0) && (kx_q == 2'd0);
        issue      = (state_q == S_RUN) && !stall;

        n_kx  = (kx_q == 2'd2) ? 2'd0 : kx_q + 2'd1;
        n_ky  = (kx_q != 2'd2) ? ky_q : (ky_q == 2'd2) ? 2'd0 : ky_q + 2'd1;
        n_ic  = !tap_last ? ic_q : ic_last ? '0 : ic_q + ICW'(1);
        n_col = !pix_last ? col_q : col_last ? '0 : col_q + CW'(1);
        n_row = !(pix_last && col_last) ? row_q : row_last ? '0 : row_q + RW'(1);
        n_oc  = !(pix_last && col_last && row_last) ? oc_q : oc_last ? '0 : oc_q + OCW'(1);
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        oc_d      = oc_q;
        row_d     = row_q;
        col_d     = col_q;
        ic_d      = ic_q;
        ky_d      = ky_q;
        kx_d      = kx_q;
        load_addr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    load_addr = 1'b1;
                end
            end
            S_RUN: begin
                if (issue) begin
                    oc_d  = n_oc;
                    row_d = n_row;
                    col_d = n_col;
                    ic_d  = n_ic;
                    ky_d  = n_ky;
                    kx_d  = n_kx;
                    if (layer_last) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end else begin
                        load_addr = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FW'(MEM_LAT)) state_d = S_DONE;
                else                         flush_d = flush_q + FW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are precomputed for the tap about to be presented, so the
    // registered outputs line up with the issue cycle.
    always_comb begin
        a_oc  = (state_q == S_IDLE) ? oc_q  : n_oc;
        a_row = (state_q == S_IDLE) ? row_q : n_row;
        a_col = (state_q == S_IDLE) ? col_q : n_col;
        a_ic  = (state_q == S_IDLE) ? ic_q  : n_ic;
        a_ky  = (state_q == S_IDLE) ? ky_q  : n_ky;
        a_kx  = (state_q == S_IDLE) ? kx_q  : n_kx;
        tap   = 4'(a_ky) * 4'd3 + 4'(a_kx);

        pad = ((a_ky == 2'd0) && (a_row == '0)) || ((a_ky == 2'd2) && (a_row == RW'(FMAP_H - 1))) ||
              ((a_kx == 2'd0) && (a_col == '0)) || ((a_kx == 2'd2) && (a_col == CW'(FMAP_W - 1)));
        r   = (a_ky == 2'd0) ? a_row - RW'(1) : (a_ky == 2'd1) ? a_row : a_row + RW'(1);
        c   = (a_kx == 2'd0) ? a_col - CW'(1) : (a_kx == 2'd1) ? a_col : a_col + CW'(1);

        feat_addr_d = feat_addr_q;
        feat_pad_d  = feat_pad_q;
        wgt_addr_d  = wgt_addr_q;
        if (load_addr) begin
            feat_pad_d  = pad;
            feat_addr_d = pad ? '0 : FA_W'(a_ic) * FA_W'(FMAP_H * FMAP_W) + FA_W'(r) * FA_W'(FMAP_W) + FA_W'(c);
            wgt_addr_d  = (WA_W'(a_oc) * WA_W'(IN_CH) + WA_W'(a_ic)) * WA_W'(9) + WA_W'(tap);
        end
    end

    // Delay line shifts every cycle, stalled or not, so in-flight reads still complete.
    always_comb begin
        head.issue = issue;
        head.first = first;
        head.last  = pix_last;
        head.oc    = oc_q;
        head.row   = row_q;
        head.col   = col_q;
        dl_d       = {dl_q[DL-1:1], head};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            flush_q     <= '0;
            oc_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ic_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            feat_addr_q <= '0;
            feat_pad_q  <= 1'b0;
            wgt_addr_q  <= '0;
            dl_q        <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            oc_q        <= oc_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ic_q        <= ic_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            feat_addr_q <= feat_addr_d;
            feat_pad_q  <= feat_pad_d;
            wgt_addr_q  <= wgt_addr_d;
            dl_q        <= dl_d;
        end
    end

    assign busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done          = (state_q == S_DONE);
    assign feat_addr     = feat_addr_q;
    assign feat_pad      = feat_pad_q;
    assign wgt_addr      = wgt_addr_q;
    assign mac_en        = dl_q[MEM_LAT].issue;
    assign mac_clr       = dl_q[MEM_LAT].issue & dl_q[MEM_LAT].first;
    assign valid_in_bias = dl_q[DL].issue & dl_q[DL].last;
    assign bias_addr     = valid_in_bias ? dl_q[DL].oc  : '0;
    assign out_row       = valid_in_bias ? dl_q[DL].row : '0;
    assign out_col       = valid_in_bias ? dl_q[DL].col : '0;
    assign unused_first  = dl_q[DL].first;

endmodule

// File: tb/tb_conv_sequencer_layer6.sv
// Scoreboard bench for conv_sequencer_layer6: three instances (MEM_LAT 2, 1, 4) share stimulus;
// expected MAC/bias/done events are queued at issue time and matched when the DUTs produce them.
module tb_conv_sequencer_layer6;
    localparam int IN_CH = 2;
    localparam int OUT_CH = 2;
    localparam int FH = 4;
    localparam int FW = 4;
    localparam int TOTAL = OUT_CH * FH * FW * IN_CH * 9;

    typedef struct { int dut; int cyc; bit first; } mac_ev_t;
    typedef struct { int dut; int cyc; int oc; int row; int col; } vib_ev_t;

    logic clk = 1'b0;
    logic rst, start, stall;
    logic [2:0] busy_w, done_w, feat_pad_w, mac_en_w, mac_clr_w, vib_w, ba_w;
    logic [2:0][19:0] fa_w, wa_w;
    logic [2:0][1:0] row_w, col_w;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int lat [3];
    mac_ev_t macq [$];
    vib_ev_t vibq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_sequencer_layer6 #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .FMAP_H(FH), .FMAP_W(FW), .MEM_LAT(2), .FA_W(20), .WA_W(20)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy_w[0]), .done(done_w[0]),
        .feat_addr(fa_w[0]), .feat_pad(feat_pad_w[0]), .wgt_addr(wa_w[0]), .bias_addr(ba_w[0]),
        .mac_en(mac_en_w[0]), .mac_clr(mac_clr_w[0]), .valid_in_bias(vib_w[0]), .out_row(row_w[0]), .out_col(col_w[0]));
    conv_sequencer_layer6 #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .FMAP_H(FH), .FMAP_W(FW), .MEM_LAT(1), .FA_W(20), .WA_W(20)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy_w[1]), .done(done_w[1]),
        .feat_addr(fa_w[1]), .feat_pad(feat_pad_w[1]), .wgt_addr(wa_w[1]), .bias_addr(ba_w[1]),
        .mac_en(mac_en_w[1]), .mac_clr(mac_clr_w[1]), .valid_in_bias(vib_w[1]), .out_row(row_w[1]), .out_col(col_w[1]));
    conv_sequencer_layer6 #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .FMAP_H(FH), .FMAP_W(FW), .MEM_LAT(4), .FA_W(20), .WA_W(20)) u_l4 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy_w[2]), .done(done_w[2]),
        .feat_addr(fa_w[2]), .feat_pad(feat_pad_w[2]), .wgt_addr(wa_w[2]), .bias_addr(ba_w[2]),
        .mac_en(mac_en_w[2]), .mac_clr(mac_clr_w[2]), .valid_in_bias(vib_w[2]), .out_row(row_w[2]), .out_col(col_w[2]));

    // One layer run; entered and left just after a rising edge.
    task automatic run_layer(input int stall_at, input int stall_len, input int restart_at,
                             input int abort_at, input bit spot);
        int idx, stalled, guard, post, f;
        int mac_cnt [3];
        int vib_cnt [3];
        int done_cnt [3];
        int done_exp [3];
        bit iss, exp_pad;
        int t, ic, col, row, oc, r, c, exp_fa, exp_wa;
        mac_ev_t me;
        vib_ev_t ve;
        idx = 0; stalled = 0; guard = 0; post = 0;
        for (int k = 0; k < 3; k++) begin
            mac_cnt[k] = 0; vib_cnt[k] = 0; done_cnt[k] = 0; done_exp[k] = -1;
        end
        macq.delete();
        vibq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while ((idx < TOTAL || post < 12) && guard < 4000) begin
            guard++;
            iss = 1'b0;
            stall = 1'b0;
            start = 1'b0;
            if (idx < TOTAL) begin
                if (idx == abort_at) begin
                    rst = 1'b0;
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if ({busy_w[k], done_w[k], mac_en_w[k], mac_clr_w[k], vib_w[k], feat_pad_w[k],
                             fa_w[k], wa_w[k], ba_w[k], row_w[k], col_w[k]} !== '0) begin
                            errors++;
                            $display("FAIL abort_zero dut%0d: busy=%0d done=%0d mac_en=%0d vib=%0d fa=%0d wa=%0d, want all 0",
                                     k, busy_w[k], done_w[k], mac_en_w[k], vib_w[k], fa_w[k], wa_w[k]);
                        end
                    end
                    macq.delete();
                    vibq.delete();
                    @(posedge clk); #1;
                    rst = 1'b1;
                    repeat (4) begin
                        @(negedge clk);
                        for (int k = 0; k < 3; k++) begin
                            checks++;
                            if ({busy_w[k], done_w[k], vib_w[k], mac_en_w[k]} !== 4'b0) begin
                                errors++;
                                $display("FAIL abort_quiet dut%0d: busy=%0d done=%0d vib=%0d mac_en=%0d, want 0",
                                         k, busy_w[k], done_w[k], vib_w[k], mac_en_w[k]);
                            end
                        end
                        @(posedge clk); #1;
                    end
                    return;
                end
                if (idx == stall_at && stalled < stall_len) begin
                    stall = 1'b1;
                    stalled++;
                end
                start = (idx == restart_at) && !stall;
                iss = !stall;
            end else begin
                post++;
            end
            @(negedge clk);
            if (iss) begin
                t   = idx % 9;
                ic  = (idx / 9) % IN_CH;
                col = (idx / (9 * IN_CH)) % FW;
                row = (idx / (9 * IN_CH * FW)) % FH;
                oc  = idx / (9 * IN_CH * FW * FH);
                r   = row + t / 3 - 1;
                c   = col + t % 3 - 1;
                exp_pad = (r < 0) || (r >= FH) || (c < 0) || (c >= FW);
                exp_fa  = exp_pad ? 0 : ic * FH * FW + r * FW + c;
                exp_wa  = (oc * IN_CH + ic) * 9 + t;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (fa_w[k] !== 20'(exp_fa) || feat_pad_w[k] !== exp_pad || wa_w[k] !== 20'(exp_wa) || busy_w[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL issue dut%0d idx=%0d: got fa=%0d pad=%0d wa=%0d busy=%0d, want fa=%0d pad=%0d wa=%0d busy=1",
                                 k, idx, fa_w[k], feat_pad_w[k], wa_w[k], busy_w[k], exp_fa, exp_pad, exp_wa);
                    end
                    me.dut = k; me.cyc = cyc + lat[k]; me.first = (t == 0) && (ic == 0);
                    macq.push_back(me);
                    if (ic == IN_CH - 1 && t == 8) begin
                        ve.dut = k; ve.cyc = cyc + lat[k] + 1; ve.oc = oc; ve.row = row; ve.col = col;
                        vibq.push_back(ve);
                    end
                    if (idx == TOTAL - 1) done_exp[k] = cyc + lat[k] + 2;
                end
                if (spot && idx == 0) begin
                    checks++;
                    if (feat_pad_w[0] !== 1'b1 || fa_w[0] !== 20'd0) begin
                        errors++; $display("FAIL spot_tap0: got pad=%0d fa=%0d, want pad=1 fa=0", feat_pad_w[0], fa_w[0]);
                    end
                end
                if (spot && idx == 4) begin
                    checks++;
                    if (feat_pad_w[0] !== 1'b0 || fa_w[0] !== 20'd0) begin
                        errors++; $display("FAIL spot_tap4: got pad=%0d fa=%0d, want pad=0 fa=0", feat_pad_w[0], fa_w[0]);
                    end
                end
                if (spot && idx == 8) begin
                    checks++;
                    if (feat_pad_w[0] !== 1'b0 || fa_w[0] !== 20'd5) begin
                        errors++; $display("FAIL spot_tap8: got pad=%0d fa=%0d, want pad=0 fa=5", feat_pad_w[0], fa_w[0]);
                    end
                end
                if (spot && idx == 13) begin
                    checks++;
                    if (feat_pad_w[0] !== 1'b0 || fa_w[0] !== 20'd16) begin
                        errors++; $display("FAIL spot_ic1_tap4: got pad=%0d fa=%0d, want pad=0 fa=16", feat_pad_w[0], fa_w[0]);
                    end
                end
                if (spot && idx == 305) begin
                    checks++;
                    if (wa_w[0] !== 20'd35) begin
                        errors++; $display("FAIL spot_wgt35: got wa=%0d, want 35", wa_w[0]);
                    end
                end
                idx++;
            end
            for (int k = 0; k < 3; k++) begin
                if (mac_en_w[k]) begin
                    mac_cnt[k]++;
                    f = -1;
                    foreach (macq[i]) if (f < 0 && macq[i].dut == k) f = i;
                    checks++;
                    if (f < 0) begin
                        errors++; $display("FAIL mac_unexpected dut%0d cyc=%0d: got mac_en=1, want 0", k, cyc);
                    end else begin
                        if (macq[f].cyc !== cyc || mac_clr_w[k] !== macq[f].first) begin
                            errors++;
                            $display("FAIL mac dut%0d: got cyc=%0d clr=%0d, want cyc=%0d clr=%0d",
                                     k, cyc, mac_clr_w[k], macq[f].cyc, macq[f].first);
                        end
                        macq.delete(f);
                    end
                end else if (mac_clr_w[k]) begin
                    checks++; errors++;
                    $display("FAIL mac_clr_alone dut%0d cyc=%0d: got clr=1 with mac_en=0, want 0", k, cyc);
                end
                if (vib_w[k]) begin
                    vib_cnt[k]++;
                    f = -1;
                    foreach (vibq[i]) if (f < 0 && vibq[i].dut == k) f = i;
                    checks++;
                    if (f < 0) begin
                        errors++; $display("FAIL vib_unexpected dut%0d cyc=%0d: got valid_in_bias=1, want 0", k, cyc);
                    end else begin
                        if (vibq[f].cyc !== cyc || ba_w[k] !== 1'(vibq[f].oc) ||
                            row_w[k] !== 2'(vibq[f].row) || col_w[k] !== 2'(vibq[f].col)) begin
                            errors++;
                            $display("FAIL vib dut%0d: got cyc=%0d oc=%0d row=%0d col=%0d, want cyc=%0d oc=%0d row=%0d col=%0d",
                                     k, cyc, ba_w[k], row_w[k], col_w[k], vibq[f].cyc, vibq[f].oc, vibq[f].row, vibq[f].col);
                        end
                        vibq.delete(f);
                    end
                end else if ({ba_w[k], row_w[k], col_w[k]} !== 5'b0) begin
                    checks++; errors++;
                    $display("FAIL vib_tag_idle dut%0d: got oc=%0d row=%0d col=%0d, want 0", k, ba_w[k], row_w[k], col_w[k]);
                end
                if (done_w[k]) begin
                    done_cnt[k]++;
                    checks++;
                    if (cyc !== done_exp[k]) begin
                        errors++; $display("FAIL done_time dut%0d: got cyc=%0d, want %0d", k, cyc, done_exp[k]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        stall = 1'b0;
        checks++;
        if (guard >= 4000) begin
            errors++; $display("FAIL run_bound: got idx=%0d after %0d cycles, want %0d", idx, guard, TOTAL);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mac_cnt[k] !== TOTAL || vib_cnt[k] !== OUT_CH * FH * FW || done_cnt[k] !== 1 || busy_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL run_totals dut%0d: got mac=%0d vib=%0d done=%0d busy=%0d, want mac=%0d vib=%0d done=1 busy=0",
                         k, mac_cnt[k], vib_cnt[k], done_cnt[k], busy_w[k], TOTAL, OUT_CH * FH * FW);
            end
        end
        checks++;
        if (macq.size() != 0 || vibq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d mac and %0d vib pending, want 0", macq.size(), vibq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_w[k], done_w[k], mac_en_w[k], mac_clr_w[k], vib_w[k], feat_pad_w[k],
                 fa_w[k], wa_w[k], ba_w[k], row_w[k], col_w[k]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: busy=%0d done=%0d fa=%0d wa=%0d pad=%0d, want all 0",
                         k, busy_w[k], done_w[k], fa_w[k], wa_w[k], feat_pad_w[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b0 || mac_en_w[k] !== 1'b0) begin
                errors++; $display("FAIL idle_hold dut%0d: busy=%0d mac_en=%0d, want 0", k, busy_w[k], mac_en_w[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_run();
        run_layer(-1, 0, -1, -1, 1'b1);
    endtask

    task automatic test_stall();
        run_layer(100, 5, -1, -1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run_layer(-1, 0, 200, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_layer(-1, 0, -1, 10 * 18 + 5, 1'b0);
        run_layer(-1, 0, -1, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_layer(17, 3, -1, -1, 1'b0);
        run_layer(-1, 0, -1, -1, 1'b0);
    endtask

    initial begin
        lat[0] = 2; lat[1] = 1; lat[2] = 4;
        test_reset();
        test_full_run();
        test_stall();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
